// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the registered priority event encoder.
package prio_enc_pkg;

  localparam int unsigned MaxChan = 256;

  typedef enum int unsigned {
    PRIO_LOW  = 0,
    PRIO_HIGH = 1
  } prio_mode_e;

  typedef enum int unsigned {
    CAP_LEVEL = 0,
    CAP_EDGE  = 1
  } cap_mode_e;

  // Indices at or beyond n produce an all-zero vector.
  function automatic logic [MaxChan-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MaxChan-1:0] v;
    v = '0;
    if (idx < n && idx < MaxChan) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_sel.sv
// Combinational priority select: reports whether any bit is set and the winning index.
module prio_sel #(
  parameter int unsigned N         = 8,
  parameter int unsigned PRIO_HIGH = 1,
  localparam int unsigned W        = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         any,
  output logic [W-1:0] idx
);

  always_comb begin
    any = |vec;
    idx = '0;
    // Scan towards the winning end so the last hit overwrites earlier ones.
    if (PRIO_HIGH == prio_enc_pkg::PRIO_HIGH) begin
      for (int i = 0; i < int'(N); i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_event_encoder.sv
// Captures request lines into a pending register and grants one winner at a time
// through a valid/ready output register.
module prio_event_encoder #(
  parameter int unsigned N         = 8,
  parameter int unsigned EDGE      = 0,
  parameter int unsigned PRIO_HIGH = 1,
  localparam int unsigned W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending_o,
  output logic         ovf_o
);

  import prio_enc_pkg::onehot;
  import prio_enc_pkg::CAP_EDGE;

  logic [N-1:0] req_q;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] capture, clr, elig;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic         ovf_q, ovf_d;
  logic         out_acc;
  logic         sel_any;
  logic [W-1:0] sel_idx;

  prio_sel #(
    .N         (N),
    .PRIO_HIGH (PRIO_HIGH)
  ) u_sel (
    .vec (elig),
    .any (sel_any),
    .idx (sel_idx)
  );

  always_comb begin
    capture   = (EDGE == CAP_EDGE) ? (req_i & ~req_q) : req_i;
    out_acc   = out_valid_q & out_ready;
    clr       = out_acc ? N'(onehot(32'(out_idx_q), N)) : '0;
    // A fresh capture on the same bit wins over the accept clear.
    pending_d = (pending_q & ~clr) | capture;
    elig      = pending_q & ~mask_i & ~clr;
    ovf_d     = (EDGE == CAP_EDGE) ? |(capture & pending_q & ~clr) : 1'b0;

    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    // Stalled grants are never retracted or replaced.
    if (!out_valid_q || out_acc) begin
      out_valid_d = sel_any;
      out_idx_d   = sel_any ? sel_idx : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      req_q       <= req_i;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending_o = pending_q;
  assign ovf_o     = ovf_q;

endmodule
